gj_row_scaler: RTL

// Gauss-Jordan row-normalisation stage of the matrix inversion datapath. Takes a pivot value, obtains
// 1/pivot from the CORDIC divider (cordic_div) through a start/done handshake, then streams one

---
 rtl/matinv_pkg.sv | 39 +++
 rtl/fx_mul_sat_reg.sv | 46 ++++
 rtl/gj_row_scaler.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/matinv_pkg.sv
// Shared definitions for the matrix-inversion datapath: Q-format defaults,
// fixed-point constants, the row-scaler state encoding and a rounding multiply.
package matinv_pkg;

  localparam int DEF_WORD_LENGTH     = 16;
  localparam int DEF_FRACTION_LENGTH = 12;

  localparam logic [DEF_WORD_LENGTH-1:0] FX_ONE = DEF_WORD_LENGTH'(1) << DEF_FRACTION_LENGTH;
  localparam logic [DEF_WORD_LENGTH-1:0] FX_MAX = {1'b0, {(DEF_WORD_LENGTH-1){1'b1}}};
  localparam logic [DEF_WORD_LENGTH-1:0] FX_MIN = {1'b1, {(DEF_WORD_LENGTH-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIV_REQ,
    ST_DIV_WAIT,
    ST_SCALE,
    ST_DRAIN,
    ST_DONE,
    ST_ERR
  } gj_state_t;

  // Round-half-up product of two default-width values, clamped to the word range.
  function automatic logic [DEF_WORD_LENGTH-1:0] fx_mul_sat(
    input logic signed [DEF_WORD_LENGTH-1:0] a,
    input logic signed [DEF_WORD_LENGTH-1:0] b
  );
    logic signed [2*DEF_WORD_LENGTH-1:0] prod;
    logic signed [2*DEF_WORD_LENGTH-1:0] shf;
    prod = a * b;
    shf  = (prod + $signed((2*DEF_WORD_LENGTH)'(1) << (DEF_FRACTION_LENGTH-1))) >>> DEF_FRACTION_LENGTH;
    if (shf > $signed({{(DEF_WORD_LENGTH+1){1'b0}}, {(DEF_WORD_LENGTH-1){1'b1}}}))
      return FX_MAX;
    else if (shf < $signed({{(DEF_WORD_LENGTH+1){1'b1}}, {(DEF_WORD_LENGTH-1){1'b0}}}))
      return FX_MIN;
    else
      return shf[DEF_WORD_LENGTH-1:0];
  endfunction

endpackage

// File: rtl/fx_mul_sat_reg.sv
// Registered signed fixed-point multiply: full product, round half up,
// arithmetic shift by the fraction length, saturate to the word range.
module fx_mul_sat_reg
  import matinv_pkg::*;
#(
  parameter int WORD_LENGTH     = DEF_WORD_LENGTH,
  parameter int FRACTION_LENGTH = DEF_FRACTION_LENGTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [WORD_LENGTH-1:0] a,
  input  logic [WORD_LENGTH-1:0] b,
  output logic [WORD_LENGTH-1:0] y
);

  localparam logic signed [2*WORD_LENGTH-1:0] HALF =
    (2*WORD_LENGTH)'(1) << (FRACTION_LENGTH-1);
  localparam logic signed [2*WORD_LENGTH-1:0] SAT_MAX =
    {{(WORD_LENGTH+1){1'b0}}, {(WORD_LENGTH-1){1'b1}}};
  localparam logic signed [2*WORD_LENGTH-1:0] SAT_MIN =
    {{(WORD_LENGTH+1){1'b1}}, {(WORD_LENGTH-1){1'b0}}};

  logic signed [2*WORD_LENGTH-1:0] prod;
  logic signed [2*WORD_LENGTH-1:0] shf;
  logic        [WORD_LENGTH-1:0]   y_next;

  always_comb begin
    prod = $signed(a) * $signed(b);
    shf  = (prod + HALF) >>> FRACTION_LENGTH;
    if (shf > SAT_MAX)
      y_next = SAT_MAX[WORD_LENGTH-1:0];
    else if (shf < SAT_MIN)
      y_next = SAT_MIN[WORD_LENGTH-1:0];
    else
      y_next = shf[WORD_LENGTH-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      y <= '0;
    else if (en)
      y <= y_next;
  end

endmodule

// File: rtl/gj_row_scaler.sv
// Gauss-Jordan row normalisation: fetches 1/pivot from the divider, then
// streams one row through a saturating Q-format multiplier.
module gj_row_scaler
  import matinv_pkg::*;
#(
  parameter int WORD_LENGTH     = DEF_WORD_LENGTH,
  parameter int FRACTION_LENGTH = DEF_FRACTION_LENGTH,
  parameter int MAX_COLS        = 8,
  parameter int DIV_TIMEOUT     = 63
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [WORD_LENGTH-1:0]           pivot,
  input  logic [$clog2(MAX_COLS+1)-1:0]    row_len,
  output logic                             div_start,
  output logic [WORD_LENGTH-1:0]           div_num,
  output logic [WORD_LENGTH-1:0]           div_den,
  input  logic [WORD_LENGTH-1:0]           div_quot,
  input  logic                             div_done,
  input  logic [WORD_LENGTH-1:0]           in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [WORD_LENGTH-1:0]           out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             busy,
  output logic                             done,
  output logic                             error
);

  localparam int CW = $clog2(MAX_COLS+1);
  localparam int TW = $clog2(DIV_TIMEOUT+1);

  gj_state_t        state_reg, state_next;
  logic [WORD_LENGTH-1:0] pivot_reg, pivot_next;
  logic [WORD_LENGTH-1:0] recip_reg, recip_next;
  logic [CW-1:0]    remaining_reg, remaining_next;
  logic [TW-1:0]    tcnt_reg, tcnt_next;
  logic             error_reg, error_next;
  logic             out_valid_reg, out_valid_next;
  logic             in_fire;

  assign div_num   = WORD_LENGTH'(1) << FRACTION_LENGTH;
  assign div_den   = pivot_reg;
  assign div_start = (state_reg == ST_DIV_REQ);
  assign busy      = (state_reg != ST_IDLE);
  assign done      = (state_reg == ST_DONE);
  assign error     = error_reg;
  assign out_valid = out_valid_reg;

  // A new element may enter whenever the output register is empty or being drained.
  assign in_ready = (state_reg == ST_SCALE) && (remaining_reg != '0) &&
                    (!out_valid_reg || out_ready);
  assign in_fire  = in_valid && in_ready;

  always_comb begin
    state_next     = state_reg;
    pivot_next     = pivot_reg;
    recip_next     = recip_reg;
    remaining_next = remaining_reg;
    tcnt_next      = tcnt_reg;
    error_next     = error_reg;

    if (in_fire)
      out_valid_next = 1'b1;
    else if (out_ready)
      out_valid_next = 1'b0;
    else
      out_valid_next = out_valid_reg;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          pivot_next     = pivot;
          remaining_next = row_len;
          error_next     = 1'b0;
          if (pivot == '0 || row_len == '0 || row_len > CW'(MAX_COLS)) begin
            state_next = ST_ERR;
            error_next = 1'b1;
          end else begin
            state_next = ST_DIV_REQ;
          end
        end
      end
      ST_DIV_REQ: begin
        tcnt_next  = '0;
        state_next = ST_DIV_WAIT;
      end
      ST_DIV_WAIT: begin
        if (div_done) begin
          recip_next = div_quot;
          state_next = ST_SCALE;
        end else if (tcnt_reg == TW'(DIV_TIMEOUT-1)) begin
          state_next = ST_ERR;
          error_next = 1'b1;
        end else begin
          tcnt_next = tcnt_reg + 1'b1;
        end
      end
      ST_SCALE: begin
        if (in_fire) begin
          remaining_next = remaining_reg - 1'b1;
          if (remaining_reg == CW'(1))
            state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!out_valid_reg || out_ready)
          state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      ST_ERR:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      pivot_reg     <= '0;
      recip_reg     <= '0;
      remaining_reg <= '0;
      tcnt_reg      <= '0;
      error_reg     <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pivot_reg     <= pivot_next;
      recip_reg     <= recip_next;
      remaining_reg <= remaining_next;
      tcnt_reg      <= tcnt_next;
      error_reg     <= error_next;
      out_valid_reg <= out_valid_next;
    end
  end

  fx_mul_sat_reg #(
    .WORD_LENGTH     (WORD_LENGTH),
    .FRACTION_LENGTH (FRACTION_LENGTH)
  ) u_mul (
    .clk   (clk),
    .reset (reset),
    .en    (in_fire),
    .a     (in_data),
    .b     (recip_reg),
    .y     (out_data)
  );

endmodule
